// File: rtl/pin_bus_pkg.sv
// Shared pin-bus definitions: bus widths, arbiter FSM state encoding and
// the request bundle a requester presents to the bus.
package pin_bus_pkg;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } bus_state_t;

   // Requester index: 0 = cpu, 1 = dbg
   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DBG = 1'b1;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } bus_req_t;

endpackage

// File: rtl/pin_bus_arbiter_rr_select2.sv
// Two-way round-robin winner select.
//   req_cpu, req_dbg : requests
//   last_dbg         : 1 = dbg was served last, 0 = cpu was served last
//   win_dbg          : winner index (0 = cpu, 1 = dbg); don't-care when idle
module rr_select2
   import pin_bus_pkg::*;
(
   input  logic req_cpu,
   input  logic req_dbg,
   input  logic last_dbg,
   output logic win_dbg
);

   // dbg wins when alone, or on contention when cpu was served last.
   assign win_dbg = req_dbg & (~req_cpu | ~last_dbg);

endmodule

// File: rtl/pin_bus_arbiter.sv
// Arbitrates a CPU and a debug/loader port onto a single pin bus.
// A granted transaction drives the bus for WAIT_STATES+1 cycles, samples
// read data on the last of those edges, then pulses the owner's gnt for
// one cycle while the bus returns to idle. All outputs are registered.
//   clk, rst_n                   : clock, async active-low reset
//   cpu_* / dbg_*                : requester ports (req, we, address, wdata, gnt)
//   read_data_out                : last sampled read data (shared)
//   address/write_enable/write_data, read_data : pin bus
module pin_bus_arbiter
   import pin_bus_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 1
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_write_enable,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic [DATA_W-1:0] cpu_write_data,
   output logic              cpu_gnt,
   input  logic              dbg_req,
   input  logic              dbg_write_enable,
   input  logic [ADDR_W-1:0] dbg_address,
   input  logic [DATA_W-1:0] dbg_write_data,
   output logic              dbg_gnt,
   output logic [DATA_W-1:0] read_data_out,
   output logic [ADDR_W-1:0] address,
   output logic              write_enable,
   output logic [DATA_W-1:0] write_data,
   input  logic [DATA_W-1:0] read_data
);

   bus_state_t        state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              last_q, last_d;    // last-served requester
   logic              owner_q, owner_d;  // requester currently on the bus
   logic [ADDR_W-1:0] addr_d;
   logic              we_d;
   logic [DATA_W-1:0] wd_d;
   logic [DATA_W-1:0] rdo_d;
   logic              cpu_gnt_d, dbg_gnt_d;

   logic     win_dbg;
   bus_req_t cpu_r, dbg_r, pick_r;

   assign cpu_r  = '{we: cpu_write_enable, addr: cpu_address, wdata: cpu_write_data};
   assign dbg_r  = '{we: dbg_write_enable, addr: dbg_address, wdata: dbg_write_data};
   assign pick_r = win_dbg ? dbg_r : cpu_r;

   rr_select2 u_rr (
      .req_cpu  (cpu_req),
      .req_dbg  (dbg_req),
      .last_dbg (last_q),
      .win_dbg  (win_dbg)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= 3'd0;
         last_q        <= REQ_DBG;
         owner_q       <= REQ_CPU;
         address       <= '0;
         write_enable  <= 1'b0;
         write_data    <= '0;
         read_data_out <= '0;
         cpu_gnt       <= 1'b0;
         dbg_gnt       <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         last_q        <= last_d;
         owner_q       <= owner_d;
         address       <= addr_d;
         write_enable  <= we_d;
         write_data    <= wd_d;
         read_data_out <= rdo_d;
         cpu_gnt       <= cpu_gnt_d;
         dbg_gnt       <= dbg_gnt_d;
      end
   end

   // Next-state and next-output logic; every output is the D of a flop.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      owner_d   = owner_q;
      addr_d    = address;
      we_d      = write_enable;
      wd_d      = write_data;
      rdo_d     = read_data_out;
      cpu_gnt_d = 1'b0;
      dbg_gnt_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            addr_d = '0;
            we_d   = 1'b0;
            wd_d   = '0;
            if (cpu_req || dbg_req) begin
               // Requester fields are latched here only; later changes are ignored.
               owner_d = win_dbg;
               addr_d  = pick_r.addr;
               we_d    = pick_r.we;
               wd_d    = pick_r.wdata;
               cnt_d   = 3'(WAIT_STATES);
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == 3'd0) begin
               if (!write_enable)
                  rdo_d = read_data;
               addr_d    = '0;
               we_d      = 1'b0;
               wd_d      = '0;
               cpu_gnt_d = (owner_q == REQ_CPU);
               dbg_gnt_d = (owner_q == REQ_DBG);
               last_d    = owner_q;
               state_d   = ST_DONE;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         ST_DONE: begin
            // Requests are not looked at here; a held req is taken next cycle.
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_pin_bus_arbiter.sv
module tb_pin_bus_arbiter;
   import pin_bus_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // DUT A: WAIT_STATES=1
   logic              cpu_req, cpu_we, dbg_req, dbg_we;
   logic [ADDR_W-1:0] cpu_addr, dbg_addr, addr;
   logic [DATA_W-1:0] cpu_wd, dbg_wd, rdo, wd, rd;
   logic              cpu_gnt, dbg_gnt, we;

   // DUT B: WAIT_STATES=0
   logic              b_cpu_req, b_cpu_we, b_dbg_req, b_dbg_we;
   logic [ADDR_W-1:0] b_cpu_addr, b_dbg_addr, b_addr;
   logic [DATA_W-1:0] b_cpu_wd, b_dbg_wd, b_rdo, b_wd, b_rd;
   logic              b_cpu_gnt, b_dbg_gnt, b_we;

   int total = 0;
   int bad   = 0;

   pin_bus_arbiter #(.WAIT_STATES(1)) u_a (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_write_enable(cpu_we), .cpu_address(cpu_addr),
      .cpu_write_data(cpu_wd), .cpu_gnt(cpu_gnt),
      .dbg_req(dbg_req), .dbg_write_enable(dbg_we), .dbg_address(dbg_addr),
      .dbg_write_data(dbg_wd), .dbg_gnt(dbg_gnt),
      .read_data_out(rdo), .address(addr), .write_enable(we),
      .write_data(wd), .read_data(rd)
   );

   pin_bus_arbiter #(.WAIT_STATES(0)) u_b (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(b_cpu_req), .cpu_write_enable(b_cpu_we), .cpu_address(b_cpu_addr),
      .cpu_write_data(b_cpu_wd), .cpu_gnt(b_cpu_gnt),
      .dbg_req(b_dbg_req), .dbg_write_enable(b_dbg_we), .dbg_address(b_dbg_addr),
      .dbg_write_data(b_dbg_wd), .dbg_gnt(b_dbg_gnt),
      .read_data_out(b_rdo), .address(b_addr), .write_enable(b_we),
      .write_data(b_wd), .read_data(b_rd)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_a(input string tag);
      chk({tag, ".addr"}, 32'(addr), 0);
      chk({tag, ".we"},   32'(we),   0);
      chk({tag, ".wd"},   32'(wd),   0);
   endtask

   initial begin
      rst_n = 1'b0;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wd = 0;
      dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wd = 0; rd = 0;
      b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wd = 0;
      b_dbg_req = 0; b_dbg_we = 0; b_dbg_addr = 0; b_dbg_wd = 0; b_rd = 0;

      tick(); tick();
      chk_idle_a("rst");
      chk("rst.rdo", 32'(rdo), 0);
      chk("rst.cgnt", 32'(cpu_gnt), 0);
      chk("rst.dgnt", 32'(dbg_gnt), 0);
      rst_n = 1'b1;
      tick();
      chk_idle_a("idle");

      // CPU read, 0x12 -> 0xA5; req dropped during ACCESS must not abort
      rd = 8'hA5; cpu_req = 1; cpu_we = 0; cpu_addr = 7'h12;
      tick();
      chk("rd.addr1", 32'(addr), 32'h12);
      chk("rd.we1", 32'(we), 0);
      chk("rd.gnt1", 32'(cpu_gnt), 0);
      cpu_req = 0;
      tick();
      chk("rd.addr2", 32'(addr), 32'h12);
      chk("rd.gnt2", 32'(cpu_gnt), 0);
      tick();
      chk("rd.gnt3", 32'(cpu_gnt), 1);
      chk("rd.dgnt3", 32'(dbg_gnt), 0);
      chk("rd.rdo", 32'(rdo), 32'hA5);
      chk_idle_a("rd.done");
      tick();
      chk("rd.gnt4", 32'(cpu_gnt), 0);

      // Debug write 0x3C -> 0x7F; read data must not be captured
      rd = 8'h5A; dbg_req = 1; dbg_we = 1; dbg_addr = 7'h7F; dbg_wd = 8'h3C;
      tick();
      chk("wr.we1", 32'(we), 1);
      chk("wr.wd1", 32'(wd), 32'h3C);
      chk("wr.addr1", 32'(addr), 32'h7F);
      dbg_req = 0;
      tick();
      chk("wr.we2", 32'(we), 1);
      chk("wr.wd2", 32'(wd), 32'h3C);
      tick();
      chk("wr.dgnt", 32'(dbg_gnt), 1);
      chk("wr.cgnt", 32'(cpu_gnt), 0);
      chk("wr.rdo", 32'(rdo), 32'hA5);
      chk_idle_a("wr.done");
      tick();
      chk("wr.dgnt4", 32'(dbg_gnt), 0);

      // Contention: both held high, reads; order cpu, dbg, cpu, dbg
      dbg_we = 0; cpu_we = 0; rd = 8'h00;
      cpu_addr = 7'h11; dbg_addr = 7'h22;
      cpu_req = 1; dbg_req = 1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         chk("rr.excl", 32'(cpu_gnt & dbg_gnt), 0);
         if (i % 4 == 1)
            chk($sformatf("rr.addr%0d", i), 32'(addr), (i % 8 == 1) ? 32'h11 : 32'h22);
         if (i % 4 == 3) begin
            chk($sformatf("rr.cgnt%0d", i), 32'(cpu_gnt), (i % 8 == 3) ? 1 : 0);
            chk($sformatf("rr.dgnt%0d", i), 32'(dbg_gnt), (i % 8 == 7) ? 1 : 0);
         end
      end
      cpu_req = 0; dbg_req = 0;
      tick();
      chk_idle_a("rr.end");

      // Address change during ACCESS is ignored
      rd = 8'h77; cpu_addr = 7'h01; cpu_req = 1;
      tick();
      chk("hold.addr1", 32'(addr), 32'h01);
      cpu_addr = 7'h02; cpu_req = 0;
      tick();
      chk("hold.addr2", 32'(addr), 32'h01);
      tick();
      chk("hold.gnt", 32'(cpu_gnt), 1);
      chk("hold.addr3", 32'(addr), 0);
      chk("hold.rdo", 32'(rdo), 32'h77);
      tick();

      // Reset in 2nd ACCESS cycle of a write
      cpu_we = 1; cpu_addr = 7'h33; cpu_wd = 8'h44; cpu_req = 1;
      tick();
      chk("ra.we1", 32'(we), 1);
      cpu_req = 0;
      tick();
      chk("ra.we2", 32'(we), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("ra.we", 32'(we), 0);
      chk("ra.addr", 32'(addr), 0);
      chk("ra.wd", 32'(wd), 0);
      chk("ra.rdo", 32'(rdo), 0);
      chk("ra.cgnt", 32'(cpu_gnt), 0);
      tick();
      chk("ra.cgnt2", 32'(cpu_gnt), 0);
      chk("ra.dgnt2", 32'(dbg_gnt), 0);
      rst_n = 1'b1;
      tick();
      chk_idle_a("ra.post");
      chk("ra.cgnt3", 32'(cpu_gnt), 0);
      tick();
      chk("ra.cgnt4", 32'(cpu_gnt), 0);

      // WAIT_STATES=0: held CPU req, 3 reads, gnt every 3 cycles
      b_cpu_addr = 7'h05; b_cpu_req = 1;
      for (int i = 1; i <= 9; i++) begin
         tick();
         chk($sformatf("ws0.gnt%0d", i), 32'(b_cpu_gnt), (i % 3 == 2) ? 1 : 0);
         chk($sformatf("ws0.addr%0d", i), 32'(b_addr), (i % 3 == 1) ? 32'h05 : 0);
         if (i % 3 == 1)
            b_rd = 8'(8'h10 + i);
         if (i % 3 == 2)
            chk($sformatf("ws0.rdo%0d", i), 32'(b_rdo), 32'(8'h10 + i - 1));
      end
      b_cpu_req = 0;
      tick();
      chk("ws0.idle", 32'(b_addr), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
